// File: rtl/alu_rs_pkg.sv
// alu_rs_pkg -- shared definitions for the ALU reservation station.
// Provides the operand/opcode/address/ROB-tag types, the entry-count
// constants, TRUE/FALSE, and the CDB tag-lookup helper used by both
// the issue path and the per-entry wakeup path.
package alu_rs_pkg;

  localparam int RS_SIZE_LOG2 = 3;
  localparam int RS_SIZE      = 1 << RS_SIZE_LOG2;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef logic [31:0]             DATA_TYPE;
  typedef logic [31:0]             ADDR_TYPE;
  typedef logic [3:0]              ROB_INDEX_TYPE;
  typedef logic [RS_SIZE_LOG2-1:0] RS_INDEX_TYPE;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3,
    OP_XOR  = 4'd4,  OP_SLL  = 4'd5,  OP_SRL  = 4'd6,  OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,  OP_SLTU = 4'd9,  OP_LUI  = 4'd10, OP_AUIPC = 4'd11,
    OP_JAL  = 4'd12, OP_JALR = 4'd13, OP_BEQ  = 4'd14, OP_BNE  = 4'd15
  } OPENUM_TYPE;

  // Result of looking an operand tag up on the broadcast buses.
  typedef struct packed {
    logic     hit;
    DATA_TYPE val;
  } WAKE_TYPE;

  // The ALU bus wins if both buses carry the same tag (cannot happen with
  // unique ROB tags, but keeps the result deterministic).
  function automatic WAKE_TYPE cdb_lookup(
    input ROB_INDEX_TYPE tag,
    input logic          a_en,
    input ROB_INDEX_TYPE a_tag,
    input DATA_TYPE      a_res,
    input logic          l_en,
    input ROB_INDEX_TYPE l_tag,
    input DATA_TYPE      l_res
  );
    WAKE_TYPE w;
    w.hit = FALSE;
    w.val = '0;
    if (a_en && (a_tag == tag)) begin
      w.hit = TRUE;
      w.val = a_res;
    end else if (l_en && (l_tag == tag)) begin
      w.hit = TRUE;
      w.val = l_res;
    end else begin
      w.hit = FALSE;
    end
    return w;
  endfunction

endpackage

// File: rtl/rs_select.sv
// rs_select -- lowest-index priority encoders for the reservation station.
// Ports:
//   busy        in  per-entry busy bits
//   ready       in  per-entry "busy and both operands ready" bits
//   free_idx    out lowest index with busy=0,  free_found  out any free
//   ready_idx   out lowest index with ready=1, ready_found out any ready
module rs_select
  import alu_rs_pkg::*;
#(
  parameter int IDX_W = 3
) (
  input  logic [(1<<IDX_W)-1:0] busy,
  input  logic [(1<<IDX_W)-1:0] ready,
  output logic [IDX_W-1:0]      free_idx,
  output logic                  free_found,
  output logic [IDX_W-1:0]      ready_idx,
  output logic                  ready_found
);

  localparam int N = 1 << IDX_W;

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    free_idx    = '0;
    free_found  = FALSE;
    ready_idx   = '0;
    ready_found = FALSE;
    for (int i = N - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_idx   = IDX_W'(i);
        free_found = TRUE;
      end else begin
        free_found = free_found;
      end
      if (ready[i]) begin
        ready_idx   = IDX_W'(i);
        ready_found = TRUE;
      end else begin
        ready_found = ready_found;
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// alu_rs -- ALU reservation station with CDB wakeup and in-order-of-index
// dispatch of one ready entry per cycle.
// Optional feature macro: RS_LSB_CDB_EN adds the lsb_cdb_* load broadcast
// bus as a second wakeup source; without it only alu_cdb_* wakes operands.
// Ports:
//   clk_in, rst_in (async, active-high), rdy_in (0 = freeze), clr_in (flush)
//   issue_*            new instruction plus operand value/tag/busy
//   rs_full            all entries busy (from registered state)
//   alu_cdb_*, lsb_cdb_*  result broadcasts (tag + value)
//   rs_to_alu_*        registered dispatch to the ALU, ready pulses 1 cycle
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE_WIDTH = 3
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  input  logic          clr_in,
  input  logic          issue_valid,
  input  OPENUM_TYPE    issue_op,
  input  ROB_INDEX_TYPE issue_rob_index,
  input  ADDR_TYPE      issue_pc,
  input  DATA_TYPE      issue_imm,
  input  logic          issue_rs1_busy,
  input  DATA_TYPE      issue_rs1_val,
  input  ROB_INDEX_TYPE issue_rs1_tag,
  input  logic          issue_rs2_busy,
  input  DATA_TYPE      issue_rs2_val,
  input  ROB_INDEX_TYPE issue_rs2_tag,
  output logic          rs_full,
  input  logic          alu_cdb_ready,
  input  DATA_TYPE      alu_cdb_result,
  input  ROB_INDEX_TYPE alu_cdb_rob_index,
`ifdef RS_LSB_CDB_EN
  input  logic          lsb_cdb_ready,
  input  DATA_TYPE      lsb_cdb_result,
  input  ROB_INDEX_TYPE lsb_cdb_rob_index,
`endif
  output logic          rs_to_alu_ready,
  output OPENUM_TYPE    rs_to_alu_op,
  output DATA_TYPE      rs_to_alu_rs1,
  output DATA_TYPE      rs_to_alu_rs2,
  output ROB_INDEX_TYPE rs_to_alu_rob_index,
  output ADDR_TYPE      rs_to_alu_PC,
  output DATA_TYPE      rs_to_alu_imm
);

  localparam int N = 1 << RS_SIZE_WIDTH;

  // Entry storage: j = operand 1, k = operand 2.
  logic [N-1:0]  busy;
  OPENUM_TYPE    op_r  [N];
  DATA_TYPE      vj    [N];
  DATA_TYPE      vk    [N];
  ROB_INDEX_TYPE qj    [N];
  ROB_INDEX_TYPE qk    [N];
  logic [N-1:0]  rj;
  logic [N-1:0]  rk;
  ROB_INDEX_TYPE rob_r [N];
  ADDR_TYPE      pc_r  [N];
  DATA_TYPE      imm_r [N];

  logic                     lsb_en;
  DATA_TYPE                 lsb_res;
  ROB_INDEX_TYPE            lsb_tag;
  logic [N-1:0]             ready_vec;
  logic [RS_SIZE_WIDTH-1:0] free_idx;
  logic                     free_found;
  logic [RS_SIZE_WIDTH-1:0] sel_idx;
  logic                     sel_found;
  WAKE_TYPE                 wake_j [N];
  WAKE_TYPE                 wake_k [N];
  WAKE_TYPE                 iss_j;
  WAKE_TYPE                 iss_k;

`ifdef RS_LSB_CDB_EN
  assign lsb_en  = lsb_cdb_ready;
  assign lsb_res = lsb_cdb_result;
  assign lsb_tag = lsb_cdb_rob_index;
`else
  assign lsb_en  = FALSE;
  assign lsb_res = '0;
  assign lsb_tag = '0;
`endif

  assign rs_full   = &busy;
  assign ready_vec = busy & rj & rk;

  rs_select #(.IDX_W(RS_SIZE_WIDTH)) u_select (
    .busy        (busy),
    .ready       (ready_vec),
    .free_idx    (free_idx),
    .free_found  (free_found),
    .ready_idx   (sel_idx),
    .ready_found (sel_found)
  );

  // Broadcast lookups for stored tags and for the operands being issued.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      wake_j[i] = cdb_lookup(qj[i], alu_cdb_ready, alu_cdb_rob_index, alu_cdb_result,
                             lsb_en, lsb_tag, lsb_res);
      wake_k[i] = cdb_lookup(qk[i], alu_cdb_ready, alu_cdb_rob_index, alu_cdb_result,
                             lsb_en, lsb_tag, lsb_res);
    end
    iss_j = cdb_lookup(issue_rs1_tag, alu_cdb_ready, alu_cdb_rob_index, alu_cdb_result,
                       lsb_en, lsb_tag, lsb_res);
    iss_k = cdb_lookup(issue_rs2_tag, alu_cdb_ready, alu_cdb_rob_index, alu_cdb_result,
                       lsb_en, lsb_tag, lsb_res);
  end

  // Entry state, wakeup, dispatch and issue. Issue targets a slot that was
  // free in registered state, so it never collides with the dispatched one.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy                <= '0;
      rj                  <= '0;
      rk                  <= '0;
      rs_to_alu_ready     <= 1'b0;
      rs_to_alu_op        <= OP_ADD;
      rs_to_alu_rs1       <= '0;
      rs_to_alu_rs2       <= '0;
      rs_to_alu_rob_index <= '0;
      rs_to_alu_PC        <= '0;
      rs_to_alu_imm       <= '0;
    end else if (!rdy_in) begin
      rs_to_alu_ready <= 1'b0;
    end else if (clr_in) begin
      busy            <= '0;
      rs_to_alu_ready <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (busy[i] && !rj[i] && wake_j[i].hit) begin
          vj[i] <= wake_j[i].val;
          rj[i] <= 1'b1;
        end
        if (busy[i] && !rk[i] && wake_k[i].hit) begin
          vk[i] <= wake_k[i].val;
          rk[i] <= 1'b1;
        end
      end

      if (sel_found) begin
        rs_to_alu_ready     <= 1'b1;
        rs_to_alu_op        <= op_r[sel_idx];
        rs_to_alu_rs1       <= vj[sel_idx];
        rs_to_alu_rs2       <= vk[sel_idx];
        rs_to_alu_rob_index <= rob_r[sel_idx];
        rs_to_alu_PC        <= pc_r[sel_idx];
        rs_to_alu_imm       <= imm_r[sel_idx];
        busy[sel_idx]       <= 1'b0;
      end else begin
        rs_to_alu_ready <= 1'b0;
      end

      if (issue_valid && !rs_full && free_found) begin
        busy[free_idx]  <= 1'b1;
        op_r[free_idx]  <= issue_op;
        rob_r[free_idx] <= issue_rob_index;
        pc_r[free_idx]  <= issue_pc;
        imm_r[free_idx] <= issue_imm;
        qj[free_idx]    <= issue_rs1_tag;
        qk[free_idx]    <= issue_rs2_tag;
        rj[free_idx]    <= !issue_rs1_busy || iss_j.hit;
        rk[free_idx]    <= !issue_rs2_busy || iss_k.hit;
        vj[free_idx]    <= !issue_rs1_busy ? issue_rs1_val : iss_j.val;
        vk[free_idx]    <= !issue_rs2_busy ? issue_rs2_val : iss_k.val;
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs -- self-checking bench for alu_rs: directed scenarios followed
// by randomized traffic, all compared against a slot-table reference model.
module tb_alu_rs;
  import alu_rs_pkg::*;

  localparam int N = 8;
`ifdef RS_LSB_CDB_EN
  localparam bit LSB_ON = 1'b1;
`else
  localparam bit LSB_ON = 1'b0;
`endif

  logic clk_in = 1'b0;
  logic rst_in, rdy_in, clr_in, issue_valid;
  OPENUM_TYPE issue_op;
  ROB_INDEX_TYPE issue_rob_index, issue_rs1_tag, issue_rs2_tag;
  ADDR_TYPE issue_pc;
  DATA_TYPE issue_imm, issue_rs1_val, issue_rs2_val;
  logic issue_rs1_busy, issue_rs2_busy, rs_full;
  logic alu_cdb_ready, lsb_cdb_ready;
  DATA_TYPE alu_cdb_result, lsb_cdb_result;
  ROB_INDEX_TYPE alu_cdb_rob_index, lsb_cdb_rob_index;
  logic rs_to_alu_ready;
  OPENUM_TYPE rs_to_alu_op;
  DATA_TYPE rs_to_alu_rs1, rs_to_alu_rs2, rs_to_alu_imm;
  ROB_INDEX_TYPE rs_to_alu_rob_index;
  ADDR_TYPE rs_to_alu_PC;

  alu_rs #(.RS_SIZE_WIDTH(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_rob_index(issue_rob_index),
    .issue_pc(issue_pc), .issue_imm(issue_imm),
    .issue_rs1_busy(issue_rs1_busy), .issue_rs1_val(issue_rs1_val), .issue_rs1_tag(issue_rs1_tag),
    .issue_rs2_busy(issue_rs2_busy), .issue_rs2_val(issue_rs2_val), .issue_rs2_tag(issue_rs2_tag),
    .rs_full(rs_full),
    .alu_cdb_ready(alu_cdb_ready), .alu_cdb_result(alu_cdb_result),
    .alu_cdb_rob_index(alu_cdb_rob_index),
`ifdef RS_LSB_CDB_EN
    .lsb_cdb_ready(lsb_cdb_ready), .lsb_cdb_result(lsb_cdb_result),
    .lsb_cdb_rob_index(lsb_cdb_rob_index),
`endif
    .rs_to_alu_ready(rs_to_alu_ready), .rs_to_alu_op(rs_to_alu_op),
    .rs_to_alu_rs1(rs_to_alu_rs1), .rs_to_alu_rs2(rs_to_alu_rs2),
    .rs_to_alu_rob_index(rs_to_alu_rob_index), .rs_to_alu_PC(rs_to_alu_PC),
    .rs_to_alu_imm(rs_to_alu_imm)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: a table of waiting instructions.
  typedef struct {
    bit            busy;
    OPENUM_TYPE    op;
    bit            r1, r2;
    DATA_TYPE      v1, v2;
    ROB_INDEX_TYPE t1, t2, rob;
    ADDR_TYPE      pc;
    DATA_TYPE      imm;
  } ent_t;
  ent_t m[N];
  bit e_ready;
  OPENUM_TYPE e_op;
  DATA_TYPE e_rs1, e_rs2, e_imm;
  ROB_INDEX_TYPE e_rob;
  ADDR_TYPE e_pc;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m[i].busy = 1'b0;
    e_ready = 1'b0; e_op = OP_ADD; e_rs1 = '0; e_rs2 = '0;
    e_rob = '0; e_pc = '0; e_imm = '0;
  endtask

  // Does a broadcast this cycle carry the result for this tag?
  task automatic bus_value(input ROB_INDEX_TYPE tag, output bit hit, output DATA_TYPE val);
    hit = 1'b0; val = '0;
    if (alu_cdb_ready && alu_cdb_rob_index == tag) begin hit = 1'b1; val = alu_cdb_result; end
    else if (LSB_ON && lsb_cdb_ready && lsb_cdb_rob_index == tag) begin
      hit = 1'b1; val = lsb_cdb_result;
    end
  endtask

  function automatic bit model_full();
    for (int i = 0; i < N; i++) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  // Advance the model across one clock edge using the current inputs.
  task automatic model_edge();
    int pick, slot;
    bit hit, full;
    DATA_TYPE v;
    if (rst_in) begin model_reset(); return; end
    if (!rdy_in) begin e_ready = 1'b0; return; end
    if (clr_in) begin
      for (int i = 0; i < N; i++) m[i].busy = 1'b0;
      e_ready = 1'b0; return;
    end
    full = model_full();
    pick = -1; slot = -1;
    for (int i = N - 1; i >= 0; i--) begin
      if (m[i].busy && m[i].r1 && m[i].r2) pick = i;
      if (!m[i].busy) slot = i;
    end
    if (!issue_valid || full) slot = -1;
    if (pick >= 0) begin
      e_ready = 1'b1; e_op = m[pick].op; e_rs1 = m[pick].v1; e_rs2 = m[pick].v2;
      e_rob = m[pick].rob; e_pc = m[pick].pc; e_imm = m[pick].imm;
      m[pick].busy = 1'b0;
    end else e_ready = 1'b0;
    for (int i = 0; i < N; i++) if (m[i].busy) begin
      if (!m[i].r1) begin bus_value(m[i].t1, hit, v); if (hit) begin m[i].r1 = 1'b1; m[i].v1 = v; end end
      if (!m[i].r2) begin bus_value(m[i].t2, hit, v); if (hit) begin m[i].r2 = 1'b1; m[i].v2 = v; end end
    end
    if (slot >= 0) begin
      m[slot].busy = 1'b1; m[slot].op = issue_op; m[slot].rob = issue_rob_index;
      m[slot].pc = issue_pc; m[slot].imm = issue_imm;
      m[slot].t1 = issue_rs1_tag; m[slot].t2 = issue_rs2_tag;
      m[slot].r1 = !issue_rs1_busy; m[slot].v1 = issue_rs1_val;
      m[slot].r2 = !issue_rs2_busy; m[slot].v2 = issue_rs2_val;
      if (issue_rs1_busy) begin bus_value(issue_rs1_tag, hit, v); if (hit) begin m[slot].r1 = 1'b1; m[slot].v1 = v; end end
      if (issue_rs2_busy) begin bus_value(issue_rs2_tag, hit, v); if (hit) begin m[slot].r2 = 1'b1; m[slot].v2 = v; end end
    end
  endtask

  task automatic compare_all();
    check("rs_full", 64'(rs_full), 64'(model_full()));
    check("ready", 64'(rs_to_alu_ready), 64'(e_ready));
    check("op", 64'(rs_to_alu_op), 64'(e_op));
    check("rs1", 64'(rs_to_alu_rs1), 64'(e_rs1));
    check("rs2", 64'(rs_to_alu_rs2), 64'(e_rs2));
    check("rob", 64'(rs_to_alu_rob_index), 64'(e_rob));
    check("pc", 64'(rs_to_alu_PC), 64'(e_pc));
    check("imm", 64'(rs_to_alu_imm), 64'(e_imm));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk_in);
    #1;
    compare_all();
  endtask

  task automatic idle();
    rdy_in = 1'b1; clr_in = 1'b0; issue_valid = 1'b0; issue_op = OP_ADD;
    issue_rob_index = '0; issue_pc = '0; issue_imm = '0;
    issue_rs1_busy = 1'b0; issue_rs1_val = '0; issue_rs1_tag = '0;
    issue_rs2_busy = 1'b0; issue_rs2_val = '0; issue_rs2_tag = '0;
    alu_cdb_ready = 1'b0; alu_cdb_result = '0; alu_cdb_rob_index = '0;
    lsb_cdb_ready = 1'b0; lsb_cdb_result = '0; lsb_cdb_rob_index = '0;
  endtask

  task automatic issue(input OPENUM_TYPE op, input ROB_INDEX_TYPE rob,
                       input bit b1, input DATA_TYPE v1, input ROB_INDEX_TYPE t1,
                       input bit b2, input DATA_TYPE v2, input ROB_INDEX_TYPE t2);
    issue_valid = 1'b1; issue_op = op; issue_rob_index = rob;
    issue_pc = 32'h1000 + 32'(rob) * 32'd4; issue_imm = 32'(rob) + 32'd100;
    issue_rs1_busy = b1; issue_rs1_val = v1; issue_rs1_tag = t1;
    issue_rs2_busy = b2; issue_rs2_val = v2; issue_rs2_tag = t2;
  endtask

  task automatic broadcast(input ROB_INDEX_TYPE tag, input DATA_TYPE val);
    alu_cdb_ready = 1'b1; alu_cdb_rob_index = tag; alu_cdb_result = val;
  endtask

  initial begin
    idle();
    model_reset();
    rst_in = 1'b1;
    #2;
    check("reset_ready", 64'(rs_to_alu_ready), 64'd0);
    check("reset_full", 64'(rs_full), 64'd0);
    tick(); tick();
    rst_in = 1'b0;

    // Both operands ready: dispatch one edge after the issue edge, one cycle only.
    issue(OP_ADD, 4'd3, 1'b0, 32'd5, 4'd0, 1'b0, 32'd7, 4'd0);
    tick(); idle();
    check("lat_early", 64'(rs_to_alu_ready), 64'd0);
    tick();
    check("lat_ready", 64'(rs_to_alu_ready), 64'd1);
    check("lat_rs1", 64'(rs_to_alu_rs1), 64'd5);
    check("lat_rs2", 64'(rs_to_alu_rs2), 64'd7);
    check("lat_rob", 64'(rs_to_alu_rob_index), 64'd3);
    tick();
    check("lat_once", 64'(rs_to_alu_ready), 64'd0);

    // Wake a waiting operand from the ALU bus.
    issue(OP_SUB, 4'd6, 1'b1, 32'd0, 4'd4, 1'b0, 32'd1, 4'd0);
    tick(); idle(); tick();
    broadcast(4'd4, 32'h10);
    tick(); idle();
    check("wake_wait", 64'(rs_to_alu_ready), 64'd0);
    tick();
    check("wake_ready", 64'(rs_to_alu_ready), 64'd1);
    check("wake_rs1", 64'(rs_to_alu_rs1), 64'h10);

    // Capture at issue from a same-cycle broadcast.
    issue(OP_AND, 4'd7, 1'b1, 32'd0, 4'd2, 1'b0, 32'd3, 4'd0);
    broadcast(4'd2, 32'd9);
    tick(); idle(); tick();
    check("cap_ready", 64'(rs_to_alu_ready), 64'd1);
    check("cap_rs1", 64'(rs_to_alu_rs1), 64'd9);

    // Fill every slot with unresolved operands, then try a ninth.
    for (int i = 0; i < N; i++) begin
      issue(OP_OR, ROB_INDEX_TYPE'(i), 1'b1, 32'd0, ROB_INDEX_TYPE'(8 + i), 1'b0, 32'd2, 4'd0);
      tick();
    end
    check("full_set", 64'(rs_full), 64'd1);
    issue(OP_XOR, 4'd9, 1'b0, 32'd1, 4'd0, 1'b0, 32'd1, 4'd0);
    tick(); idle(); tick();
    check("ninth_ignored", 64'(rs_to_alu_ready), 64'd0);
    broadcast(4'd13, 32'h55);
    tick(); idle(); tick();
    check("e5_ready", 64'(rs_to_alu_ready), 64'd1);
    check("e5_rob", 64'(rs_to_alu_rob_index), 64'd5);
    check("e5_rs1", 64'(rs_to_alu_rs1), 64'h55);
    check("full_drop", 64'(rs_full), 64'd0);

    // Flush three ready entries.
    clr_in = 1'b1; tick(); idle();
    for (int i = 0; i < 3; i++) begin
      issue(OP_SLL, ROB_INDEX_TYPE'(i), 1'b1, 32'd0, 4'd7, 1'b0, 32'd4, 4'd0);
      tick();
    end
    idle(); broadcast(4'd7, 32'h77); tick(); idle();
    clr_in = 1'b1; tick(); idle();
    check("clr_nodisp", 64'(rs_to_alu_ready), 64'd0);
    check("clr_full", 64'(rs_full), 64'd0);
    tick();

    // Stall with rdy_in low: nothing moves, clr and issue ignored.
    for (int i = 0; i < 3; i++) begin
      issue(OP_SRL, ROB_INDEX_TYPE'(10 + i), 1'b1, 32'd0, 4'd1, 1'b0, 32'd8, 4'd0);
      tick();
    end
    idle(); broadcast(4'd1, 32'h11); tick(); idle();
    for (int i = 0; i < 4; i++) begin
      rdy_in = 1'b0; clr_in = (i == 1);
      issue(OP_SRA, 4'd15, 1'b0, 32'd1, 4'd0, 1'b0, 32'd1, 4'd0);
      tick();
      check("stall_nodisp", 64'(rs_to_alu_ready), 64'd0);
    end
    idle();
    for (int i = 0; i < 4; i++) tick();

    // Reset in mid-operation drops pending entries.
    issue(OP_SLT, 4'd2, 1'b1, 32'd0, 4'd5, 1'b0, 32'd0, 4'd0);
    tick(); idle();
    #3 rst_in = 1'b1;
    #1;
    check("async_ready", 64'(rs_to_alu_ready), 64'd0);
    check("async_full", 64'(rs_full), 64'd0);
    check("async_rs1", 64'(rs_to_alu_rs1), 64'd0);
    tick(); rst_in = 1'b0;
    broadcast(4'd5, 32'h5); tick(); idle(); tick();
    check("post_rst_nodisp", 64'(rs_to_alu_ready), 64'd0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      idle();
      rdy_in = ($urandom_range(0, 19) != 0);
      clr_in = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 9) < 6) begin
        issue(OPENUM_TYPE'($urandom_range(0, 15)), ROB_INDEX_TYPE'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), $urandom, ROB_INDEX_TYPE'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), $urandom, ROB_INDEX_TYPE'($urandom_range(0, 15)));
        issue_pc = $urandom; issue_imm = $urandom;
      end
      if ($urandom_range(0, 1) == 1) broadcast(ROB_INDEX_TYPE'($urandom_range(0, 15)), $urandom);
      if ($urandom_range(0, 1) == 1) begin
        lsb_cdb_ready = 1'b1;
        lsb_cdb_rob_index = ROB_INDEX_TYPE'($urandom_range(0, 15));
        lsb_cdb_result = $urandom;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
